instr_exec_buffer: RTL and testbench

Parametrised instruction register with an integrated execution unit. It accepts opcode/operand pairs over a valid/ready handshake and computes each result, single-cycle or iterative depending on the opcode. Each completed instruction is stored in a DEPTH-entry buffer with a per-entry valid bit, and the buffer is read back through a registered read port. It sits between the stimulus/transaction side of the lab DUT and any consumer of computed instruction words.

---
 rtl/instr_register_pkg.sv | 25 ++
 rtl/instr_exec_alu.sv | 94 +++++++++
 rtl/instr_exec_buffer.sv | 186 ++++++++++++++++++
 tb/tb_instr_exec_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction execution buffer: opcodes, FSM states, latency constant.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXEC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Number of EXEC cycles spent by every non-iterative opcode.
    localparam int EXEC_SINGLE_LAT = 1;

endpackage

// File: rtl/instr_exec_alu.sv
// Execution unit: combinational single-cycle operations plus an iterative
// square-and-multiply engine for POW that consumes one exponent bit per cycle.
module instr_exec_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = 32,
    parameter int RES_WIDTH = 2 * OP_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  opcode_t              i_opcode,
    input  logic [OP_WIDTH-1:0]  i_a,
    input  logic [OP_WIDTH-1:0]  i_b,
    output logic [RES_WIDTH-1:0] o_result,
    output logic                 o_err,
    input  logic                 i_start,
    input  logic [OP_WIDTH-1:0]  i_start_a,
    input  logic [OP_WIDTH-1:0]  i_start_b,
    input  logic                 i_abort,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [RES_WIDTH-1:0] o_pow_result
);

    localparam int EXT = RES_WIDTH - OP_WIDTH;
    localparam int CW  = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    logic signed [RES_WIDTH-1:0] w_a_ext;
    logic signed [RES_WIDTH-1:0] w_b_ext;

    logic [RES_WIDTH-1:0] r_base;
    logic [RES_WIDTH-1:0] r_acc;
    logic [OP_WIDTH-1:0]  r_exp;
    logic                 r_neg;
    logic [CW-1:0]        r_cnt;
    logic                 r_busy;
    logic [RES_WIDTH-1:0] w_acc_next;
    logic [RES_WIDTH-1:0] w_base_next;

    assign w_a_ext = {{EXT{i_a[OP_WIDTH-1]}}, i_a};
    assign w_b_ext = {{EXT{i_b[OP_WIDTH-1]}}, i_b};

    // Single-cycle result; division by zero yields 0 without flagging an error.
    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_opcode)
            ZERO:  o_result = '0;
            PASSA: o_result = w_a_ext;
            PASSB: o_result = w_b_ext;
            ADD:   o_result = w_a_ext + w_b_ext;
            SUB:   o_result = w_a_ext - w_b_ext;
            MULT:  o_result = w_a_ext * w_b_ext;
            DIV:   if (w_b_ext != '0) o_result = w_a_ext / w_b_ext;
            MOD:   if (w_b_ext != '0) o_result = w_a_ext % w_b_ext;
            POW:   o_result = '0;
            default: o_err = 1'b1;
        endcase
    end

    assign w_acc_next   = r_exp[0] ? r_acc * r_base : r_acc;
    assign w_base_next  = r_base * r_base;
    assign o_busy       = r_busy;
    assign o_done       = r_busy && (r_cnt == CW'(OP_WIDTH - 1));
    assign o_pow_result = r_neg ? '0 : w_acc_next;

    // POW iterator: load on start, then one LSB-first exponent bit per cycle for OP_WIDTH cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_acc  <= '0;
            r_exp  <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_base <= {{EXT{i_start_a[OP_WIDTH-1]}}, i_start_a};
            r_acc  <= RES_WIDTH'(1);
            r_exp  <= i_start_b;
            r_neg  <= i_start_b[OP_WIDTH-1];
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc  <= w_acc_next;
            r_base <= w_base_next;
            r_exp  <= r_exp >> 1;
            r_cnt  <= r_cnt + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_exec_buffer.sv
// Instruction register with integrated execution unit: accepts one instruction
// at a time, executes it, commits it into a DEPTH-entry buffer, and serves a
// registered read port over that buffer.
module instr_exec_buffer
    import instr_register_pkg::*;
#(
    parameter int  OP_WIDTH  = 32,
    parameter int  DEPTH     = 32,
    parameter int  RES_WIDTH = 2 * OP_WIDTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  opcode_t              opcode,
    input  logic [OP_WIDTH-1:0]  operand_a,
    input  logic [OP_WIDTH-1:0]  operand_b,
    input  logic [AW-1:0]        write_pointer,
    output logic                 done,
    output logic [AW:0]          entry_count,
    input  logic [AW-1:0]        read_pointer,
    output logic                 rd_valid,
    output opcode_t              rd_opcode,
    output logic [OP_WIDTH-1:0]  rd_operand_a,
    output logic [OP_WIDTH-1:0]  rd_operand_b,
    output logic [RES_WIDTH-1:0] rd_result,
    output logic                 rd_err
);

    state_t r_state;
    state_t w_next_state;

    opcode_t              r_opcode;
    logic [OP_WIDTH-1:0]  r_a;
    logic [OP_WIDTH-1:0]  r_b;
    logic [AW-1:0]        r_wptr;
    logic [RES_WIDTH-1:0] r_result;
    logic                 r_err;

    opcode_t              r_mem_opcode [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_a      [DEPTH];
    logic [OP_WIDTH-1:0]  r_mem_b      [DEPTH];
    logic [RES_WIDTH-1:0] r_mem_result [DEPTH];
    logic                 r_mem_err    [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [AW:0]          r_count;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_commit;
    logic                 w_exec_exit;
    logic [RES_WIDTH-1:0] w_alu_result;
    logic                 w_alu_err;
    logic                 w_pow_busy;
    logic                 w_pow_done;
    logic [RES_WIDTH-1:0] w_pow_result;
    logic [RES_WIDTH-1:0] w_exec_result;

    assign wr_ready      = (r_state == IDLE) && !clear;
    assign w_accept      = wr_valid && wr_ready;
    assign w_commit      = (r_state == COMMIT) && !clear;
    assign w_exec_exit   = (r_state == EXEC) && (w_next_state == COMMIT);
    assign w_exec_result = (r_opcode == POW) ? w_pow_result : w_alu_result;
    assign done          = r_done;
    assign entry_count   = r_count;

    instr_exec_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_opcode     (r_opcode),
        .i_a          (r_a),
        .i_b          (r_b),
        .o_result     (w_alu_result),
        .o_err        (w_alu_err),
        .i_start      (w_accept && (opcode == POW)),
        .i_start_a    (operand_a),
        .i_start_b    (operand_b),
        .i_abort      (clear),
        .o_busy       (w_pow_busy),
        .o_done       (w_pow_done),
        .o_pow_result (w_pow_result)
    );

    // Next-state logic; clear forces IDLE from any state. A POW also leaves EXEC if the iterator is no longer busy, so the FSM cannot stall.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:   if (w_accept) w_next_state = EXEC;
            EXEC:   if ((r_opcode != POW) || w_pow_done || !w_pow_busy) w_next_state = COMMIT;
            COMMIT: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (clear) w_next_state = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // Capture the instruction on accept and its result when EXEC finishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode <= ZERO;
            r_a      <= '0;
            r_b      <= '0;
            r_wptr   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_opcode <= opcode;
                r_a      <= operand_a;
                r_b      <= operand_b;
                r_wptr   <= write_pointer;
            end
            if (w_exec_exit) begin
                r_result <= w_exec_result;
                r_err    <= w_alu_err;
            end
        end
    end

    // Entry payload storage; validity is tracked separately, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem_opcode[r_wptr] <= r_opcode;
            r_mem_a[r_wptr]      <= r_a;
            r_mem_b[r_wptr]      <= r_b;
            r_mem_result[r_wptr] <= r_result;
            r_mem_err[r_wptr]    <= r_err;
        end
    end

    // Valid bits, occupancy count and done pulse; clear overrides a same-cycle commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_valid <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_valid[r_wptr] <= 1'b1;
                if (!r_valid[r_wptr]) r_count <= r_count + 1'b1;
            end
        end
    end

    // Registered read port; invalid entries read back as all zeros.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid     <= 1'b0;
            rd_opcode    <= ZERO;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_err       <= 1'b0;
        end else if (r_valid[read_pointer]) begin
            rd_valid     <= 1'b1;
            rd_opcode    <= r_mem_opcode[read_pointer];
            rd_operand_a <= r_mem_a[read_pointer];
            rd_operand_b <= r_mem_b[read_pointer];
            rd_result    <= r_mem_result[read_pointer];
            rd_err       <= r_mem_err[read_pointer];
        end else begin
            rd_valid     <= 1'b0;
            rd_opcode    <= ZERO;
            rd_operand_a <= '0;
            rd_operand_b <= '0;
            rd_result    <= '0;
            rd_err       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_exec_buffer.sv
// Scoreboard bench for instr_exec_buffer: stimulus pushes expected entries,
// a monitor pops one on every done pulse and reads the entry back.
module tb_instr_exec_buffer;
    import instr_register_pkg::*;

    localparam int OPW   = 32;
    localparam int DEPTH = 32;
    localparam int RESW  = 64;
    localparam int AW    = 5;

    logic            clk;
    logic            reset_n;
    logic            clear;
    logic            wrValid;
    logic            wrReady;
    opcode_t         opcode;
    logic [OPW-1:0]  operandA;
    logic [OPW-1:0]  operandB;
    logic [AW-1:0]   writePointer;
    logic            done;
    logic [AW:0]     entryCount;
    logic [AW-1:0]   readPointer;
    logic            rdValid;
    opcode_t         rdOpcode;
    logic [OPW-1:0]  rdOperandA;
    logic [OPW-1:0]  rdOperandB;
    logic [RESW-1:0] rdResult;
    logic            rdErr;

    typedef struct {
        int unsigned ptr;
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        logic        err;
        int unsigned count;
    } expEntry_t;

    expEntry_t expQ[$];
    bit        modelValid [DEPTH];
    int        modelCount;
    int        checkCount;
    int        failCount;

    instr_exec_buffer #(
        .OP_WIDTH  (OPW),
        .DEPTH     (DEPTH),
        .RES_WIDTH (RESW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .wr_valid      (wrValid),
        .wr_ready      (wrReady),
        .opcode        (opcode),
        .operand_a     (operandA),
        .operand_b     (operandB),
        .write_pointer (writePointer),
        .done          (done),
        .entry_count   (entryCount),
        .read_pointer  (readPointer),
        .rd_valid      (rdValid),
        .rd_opcode     (rdOpcode),
        .rd_operand_a  (rdOperandA),
        .rd_operand_b  (rdOperandB),
        .rd_result     (rdResult),
        .rd_err        (rdErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference model: plain 64-bit signed arithmetic on sign-extended operands.
    function automatic void modelExec(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                                      output logic [63:0] res, output logic err);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = sa;
        ub  = sb;
        res = '0;
        err = 1'b0;
        case (opc)
            4'd0: res = '0;
            4'd1: res = sa;
            4'd2: res = sb;
            4'd3: res = sa + sb;
            4'd4: res = sa - sb;
            4'd5: res = sa * sb;
            4'd6: if (sb != 0) res = sa / sb;
            4'd7: if (sb != 0) res = sa % sb;
            4'd8: if (sb >= 0) res = ua ** ub;
            default: err = 1'b1;
        endcase
    endfunction

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) modelValid[i] = 1'b0;
        modelCount = 0;
    endtask

    task automatic issueOnly(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b, input int unsigned ptr);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!wrReady && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!wrReady) checkOutput("wrReadyTimeout", {63'b0, wrReady}, 64'd1);
        opcode       = opcode_t'(opc);
        operandA     = a;
        operandB     = b;
        writePointer = AW'(ptr);
        wrValid      = 1'b1;
        @(posedge clk);
        #1 wrValid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b, input int unsigned ptr);
        expEntry_t e;
        int busy;
        e.ptr = ptr;
        e.opc = opc;
        e.a   = a;
        e.b   = b;
        modelExec(opc, a, b, e.res, e.err);
        if (!modelValid[ptr]) modelCount++;
        modelValid[ptr] = 1'b1;
        e.count = modelCount;
        expQ.push_back(e);
        issueOnly(opc, a, b, ptr);
        busy = 0;
        while (busy < 200) begin
            @(negedge clk);
            if (wrReady) break;
            busy++;
        end
        checkOutput("busyCycles", 64'(busy), (opc == 4'd8) ? 64'(OPW + 1) : 64'd2);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (expQ.size() != 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drainQueue", 64'(expQ.size()), 64'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic readEntry(input int unsigned ptr);
        readPointer = AW'(ptr);
        @(negedge clk);
    endtask

    // Monitor: every done pulse pops one expected entry and reads it back.
    initial begin
        expEntry_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousDone", {63'b0, done}, 64'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("entryCount", 64'(entryCount), 64'(e.count));
                    readPointer = AW'(e.ptr);
                    @(negedge clk);
                    checkOutput("rdValid", {63'b0, rdValid}, 64'd1);
                    checkOutput("rdOpcode", {60'b0, rdOpcode}, {60'b0, e.opc});
                    checkOutput("rdOperandA", {32'b0, rdOperandA}, {32'b0, e.a});
                    checkOutput("rdOperandB", {32'b0, rdOperandB}, {32'b0, e.b});
                    checkOutput("rdResult", rdResult, e.res);
                    checkOutput("rdErr", {63'b0, rdErr}, {63'b0, e.err});
                end
            end
        end
    end

    initial begin
        logic [3:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        int          r;
        checkCount   = 0;
        failCount    = 0;
        reset_n      = 1'b0;
        clear        = 1'b0;
        wrValid      = 1'b0;
        opcode       = ZERO;
        operandA     = '0;
        operandB     = '0;
        writePointer = '0;
        readPointer  = '0;
        clearModel();

        repeat (3) @(negedge clk);
        checkOutput("resetWrReady", {63'b0, wrReady}, 64'd1);
        checkOutput("resetCount", 64'(entryCount), 64'd0);
        checkOutput("resetDone", {63'b0, done}, 64'd0);
        checkOutput("resetRdValid", {63'b0, rdValid}, 64'd0);
        checkOutput("resetRdResult", rdResult, 64'd0);
        reset_n = 1'b1;
        readEntry(7);
        checkOutput("emptyRdValid", {63'b0, rdValid}, 64'd0);
        checkOutput("emptyRdResult", rdResult, 64'd0);

        applyStimulus(4'd3, 32'd5, 32'd7, 3);
        applyStimulus(4'd4, 32'd3, -32'sd10, 0);
        applyStimulus(4'd6, 32'd7, 32'd0, 1);
        applyStimulus(4'd7, -32'sd7, 32'd3, 2);
        applyStimulus(4'd8, 32'd3, 32'd4, 4);
        applyStimulus(4'd8, 32'd2, -32'sd1, 5);
        applyStimulus(4'hF, 32'd9, 32'd9, 6);
        applyStimulus(4'd3, 32'd1, 32'd1, 3);
        applyStimulus(4'd5, 32'h8000_0000, 32'h8000_0000, 7);
        applyStimulus(4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 8);
        applyStimulus(4'd6, -32'sd7, 32'd2, 9);
        applyStimulus(4'd8, -32'sd3, 32'd45, 10);
        drain();

        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 10));
            opc = (r <= 8) ? 4'(r) : 4'($urandom_range(9, 15));
            a   = $urandom;
            if (opc == 4'd8) begin
                b = ($urandom_range(0, 3) == 0) ? -32'($urandom_range(1, 100)) : 32'($urandom_range(0, 70));
            end else begin
                b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end
            applyStimulus(opc, a, b, $urandom_range(0, DEPTH - 1));
        end
        drain();

        issueOnly(4'd8, 32'd3, 32'd5, 9);
        repeat (5) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        clearModel();
        repeat (OPW + 5) @(negedge clk);
        checkOutput("clearCount", 64'(entryCount), 64'd0);
        checkOutput("clearWrReady", {63'b0, wrReady}, 64'd1);
        for (int p = 0; p < DEPTH; p++) begin
            readEntry(p);
            checkOutput("clearRdValid", {63'b0, rdValid}, 64'd0);
        end

        applyStimulus(4'd3, 32'd10, 32'd20, 2);
        drain();
        issueOnly(4'd5, 32'd6, 32'd7, 11);
        reset_n = 1'b0;
        #1;
        checkOutput("midResetWrReady", {63'b0, wrReady}, 64'd1);
        checkOutput("midResetCount", 64'(entryCount), 64'd0);
        checkOutput("midResetDone", {63'b0, done}, 64'd0);
        checkOutput("midResetRdValid", {63'b0, rdValid}, 64'd0);
        clearModel();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("postResetCount", 64'(entryCount), 64'd0);
        readEntry(11);
        checkOutput("abortedEntryValid", {63'b0, rdValid}, 64'd0);
        readEntry(2);
        checkOutput("resetEntryValid", {63'b0, rdValid}, 64'd0);
        applyStimulus(4'd3, 32'd2, 32'd3, 11);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
